// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: request codes, PIDs, FSM states and line-coding constants for the USB TX engine
package usb_tx_pkg;
  typedef enum logic [2:0] {
    REQ_NONE  = 3'd0,
    REQ_DATA0 = 3'd1,
    REQ_DATA1 = 3'd2,
    REQ_ACK   = 3'd3,
    REQ_NAK   = 3'd4,
    REQ_STALL = 3'd5
  } tx_req_e;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_PID  = 3'd2,
    S_DATA = 3'd3,
    S_CRC  = 3'd4,
    S_EOP  = 3'd5
  } tx_state_e;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [15:0] CRC_POLY  = 16'hA001;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;
  localparam logic [2:0]  STUFF_RUN = 3'd6;
  localparam logic [7:0]  SYNC_BYTE = 8'h80;
  function automatic logic [7:0] pid_byte(input logic [2:0] req);
    logic [3:0] p;
    p = req == REQ_DATA0 ? PID_DATA0 :
        req == REQ_DATA1 ? PID_DATA1 :
        req == REQ_ACK   ? PID_ACK   :
        req == REQ_NAK   ? PID_NAK   : PID_STALL;
    return {~p, p};
  endfunction
endpackage

// File: rtl/usb_tx_crc16.sv
// usb_tx_crc16: bit-serial reflected CRC16 over payload bits, LSB-first input
module usb_tx_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc,
  output logic [7:0]  nxt_lo
);
  logic [15:0] nxt;
  assign nxt = (crc[0] ^ din) ? ({1'b0, crc[15:1]} ^ CRC_POLY) : {1'b0, crc[15:1]};
  assign nxt_lo = nxt[7:0];
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) crc <= CRC_INIT;
    else if (clr) crc <= CRC_INIT;
    else if (en) crc <= nxt;
endmodule

// File: rtl/usb_tx_engine.sv
// usb_tx_engine: serialises USB full-speed handshake and data packets with
// bit stuffing, CRC16 and NRZI line coding onto dplus_out/dminus_out.
module usb_tx_engine
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_PAYLOAD  = 64,
  parameter int OCC_W        = 7,
  parameter int STUFF_EN     = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [2:0]       tx_packet,
  input  logic [7:0]       tx_packet_data,
  input  logic [OCC_W-1:0] buff_occ,
  output logic             get_tx_data,
  output logic             tx_transfer_active,
  output logic             tx_error,
  output logic             dplus_out,
  output logic             dminus_out
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  tx_state_e        state, nxt_state;
  logic [CW-1:0]    tcnt;
  logic [7:0]       sh, pid, nxt_byte, crc_nxt_lo;
  logic [2:0]       bcnt, ones, ones_n;
  logic [1:0]       ecnt;
  logic [OCC_W-1:0] rem;
  logic [15:0]      crc;
  logic stuff, line, is_data, crc_hi;
  logic accept, req_ok, bit_end, data_end, last, stuff_n, nbit, se0;
  assign accept   = state == S_IDLE && tx_packet != 3'd0;
  assign req_ok   = tx_packet < 3'd6 &&
                    !((tx_packet == REQ_DATA0 || tx_packet == REQ_DATA1) && 32'(buff_occ) > MAX_PAYLOAD);
  assign bit_end  = state != S_IDLE && tcnt == CW'(CLKS_PER_BIT - 1);
  assign data_end = bit_end && !stuff && state inside {S_SYNC, S_PID, S_DATA, S_CRC};
  assign last     = bcnt == 3'd7;
  assign ones_n   = sh[0] ? ones + 3'd1 : 3'd0;
  assign stuff_n  = STUFF_EN != 0 && ones_n == STUFF_RUN;
  assign get_tx_data = data_end && last && rem != '0 && (state == S_DATA || (state == S_PID && is_data));
  // Byte boundaries pick the next byte; a pending stuff bit goes out before it.
  always_comb begin
    nxt_state = state;
    nxt_byte = {1'b0, sh[7:1]};
    if (last)
      case (state)
        S_SYNC: begin
          nxt_state = S_PID;
          nxt_byte = pid;
        end
        S_PID, S_DATA: begin
          nxt_state = (state == S_PID && !is_data) ? S_EOP : rem != '0 ? S_DATA : S_CRC;
          nxt_byte = rem != '0 ? tx_packet_data : state == S_PID ? ~crc[7:0] : ~crc_nxt_lo;
        end
        S_CRC: begin
          nxt_state = crc_hi ? S_EOP : S_CRC;
          nxt_byte = ~crc[15:8];
        end
        default: ;
      endcase
  end
  assign nbit = stuff_n ? 1'b0 : nxt_state == S_EOP ? 1'b1 : nxt_byte[0];
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state    <= S_IDLE;
      tcnt     <= '0;
      sh       <= '0;
      pid      <= '0;
      bcnt     <= '0;
      ones     <= '0;
      ecnt     <= '0;
      rem      <= '0;
      stuff    <= 1'b0;
      line     <= 1'b1;
      is_data  <= 1'b0;
      crc_hi   <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      tcnt <= (accept || bit_end || state == S_IDLE) ? '0 : tcnt + CW'(1);
      if (accept) begin
        tx_error <= !req_ok;
        if (req_ok) begin
          state   <= S_SYNC;
          sh      <= SYNC_BYTE;
          pid     <= pid_byte(tx_packet);
          is_data <= tx_packet == REQ_DATA0 || tx_packet == REQ_DATA1;
          rem     <= buff_occ;
          bcnt    <= '0;
          ones    <= '0;
          ecnt    <= '0;
          stuff   <= 1'b0;
          crc_hi  <= 1'b0;
          line    <= SYNC_BYTE[0];
        end
      end else if (bit_end) begin
        if (state == S_EOP) begin
          if (stuff) stuff <= 1'b0;
          else if (ecnt == 2'd2) begin
            state <= S_IDLE;
            line  <= 1'b1;
          end else ecnt <= ecnt + 2'd1;
        end else if (stuff) begin
          stuff <= 1'b0;
          line  <= sh[0] ? line : ~line;
        end else begin
          ones   <= stuff_n ? 3'd0 : ones_n;
          stuff  <= stuff_n;
          state  <= nxt_state;
          sh     <= nxt_byte;
          bcnt   <= bcnt + 3'd1;
          rem    <= rem - OCC_W'(get_tx_data);
          crc_hi <= crc_hi | (state == S_CRC && last);
          line   <= nbit ? line : ~line;
        end
      end
    end
  usb_tx_crc16 u_crc (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr    (accept),
    .en     (data_end && state == S_DATA),
    .din    (sh[0]),
    .crc    (crc),
    .nxt_lo (crc_nxt_lo)
  );
  assign se0 = state == S_EOP && !stuff;
  assign tx_transfer_active = state != S_IDLE;
  assign dplus_out  = se0 ? ecnt == 2'd2 : line;
  assign dminus_out = se0 ? 1'b0 : ~line;
endmodule

// File: tb/tb_usb_tx_engine.sv
// tb_usb_tx_engine: directed and random packets checked cycle-by-cycle against a
// bit-stream model (PID/CRC/stuffing/NRZI built from the USB line rules).
module tb_usb_tx_engine;
  localparam int CPB = 8;
  logic clk = 1'b0, n_rst = 1'b0;
  logic [2:0] tx_packet = 3'd0;
  logic [7:0] tx_packet_data = 8'd0;
  logic [6:0] buff_occ = 7'd0;
  logic get_tx_data, tx_transfer_active, tx_error, dplus_out, dminus_out;
  int vectors = 0, miscompares = 0, idx = 0;
  logic [7:0] pay [0:127];
  logic bq[$];
  logic [1:0] expq[$], obs[$];
  always #5 clk = ~clk;
  usb_tx_engine #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(64), .OCC_W(7), .STUFF_EN(1)) dut (
    .clk(clk), .n_rst(n_rst), .tx_packet(tx_packet), .tx_packet_data(tx_packet_data),
    .buff_occ(buff_occ), .get_tx_data(get_tx_data), .tx_transfer_active(tx_transfer_active),
    .tx_error(tx_error), .dplus_out(dplus_out), .dminus_out(dminus_out)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic void put_byte(input logic [7:0] v);
    for (int j = 0; j < 8; j++) bq.push_back(v[j]);
  endfunction
  // Expected line symbol per bit-time: 2'b10 J, 2'b01 K, 2'b00 SE0.
  function automatic void build(input logic [2:0] code, input int n, input logic kat);
    logic [3:0] p;
    logic [15:0] r, kv;
    logic ln;
    int ones;
    bq.delete();
    expq.delete();
    p = code == 3'd1 ? 4'h3 : code == 3'd2 ? 4'hB : code == 3'd3 ? 4'h2 : code == 3'd4 ? 4'hA : 4'hE;
    put_byte(8'h80);
    put_byte({~p, p});
    if (code <= 3'd2) begin
      r = 16'hFFFF;
      kv = 16'hB4C8;
      for (int i = 0; i < n; i++) begin
        put_byte(pay[i]);
        for (int j = 0; j < 8; j++) r = {r[14:0], 1'b0} ^ ((r[15] ^ pay[i][j]) ? 16'h8005 : 16'h0);
      end
      for (int k = 0; k < 16; k++) bq.push_back(kat ? kv[k] : ~r[15-k]);
    end
    ln = 1'b1;
    ones = 0;
    foreach (bq[k]) begin
      if (!bq[k]) ln = ~ln;
      expq.push_back(ln ? 2'b10 : 2'b01);
      ones = bq[k] ? ones + 1 : 0;
      if (ones == 6) begin
        ln = ~ln;
        expq.push_back(ln ? 2'b10 : 2'b01);
        ones = 0;
      end
    end
    expq.push_back(2'b00);
    expq.push_back(2'b00);
    expq.push_back(2'b10);
  endfunction
  task automatic send(input logic [2:0] code, input int n, input int inject_at, input int abort_at,
                      input logic kat, input string tag);
    int act, pops;
    logic pend, done;
    build(code, n, kat);
    idx = 0;
    tx_packet_data = pay[0];
    buff_occ = 7'(n);
    @(negedge clk) tx_packet = code;
    @(posedge clk);
    #1 tx_packet = 3'd0;
    obs.delete();
    act = 0;
    pops = 0;
    done = 1'b0;
    for (int c = 0; c < 8000 && !done; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        n_rst = 1'b0;
        #1;
        chk({tag, " rst outputs"}, {28'd0, dplus_out, dminus_out, tx_transfer_active, get_tx_data}, 32'h8);
        chk({tag, " rst err"}, {31'd0, tx_error}, 32'd0);
        #2 n_rst = 1'b1;
        return;
      end
      if (!tx_transfer_active) done = 1'b1;
      else begin
        act++;
        obs.push_back({dplus_out, dminus_out});
        pend = get_tx_data;
        pops += int'(pend);
        if (c == inject_at) tx_packet = 3'd3;
        @(posedge clk);
        #1 tx_packet = 3'd0;
        if (pend) begin
          idx++;
          tx_packet_data = pay[idx];
        end
      end
    end
    chk({tag, " finished"}, {31'd0, done}, 32'd1);
    chk({tag, " active cycles"}, 32'(act), 32'(expq.size() * CPB));
    chk({tag, " pops"}, 32'(pops), code <= 3'd2 ? 32'(n) : 32'd0);
    chk({tag, " err"}, {31'd0, tx_error}, 32'd0);
    for (int c = 0; c < expq.size() * CPB; c++)
      chk($sformatf("%s line c%0d", tag, c), {30'd0, c < obs.size() ? obs[c] : 2'bxx}, {30'd0, expq[c / CPB]});
  endtask
  task automatic bad_req(input logic [2:0] code, input int n, input string tag);
    @(negedge clk);
    tx_packet = code;
    buff_occ = 7'(n);
    @(posedge clk);
    #1 tx_packet = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({tag, " err"}, {31'd0, tx_error}, 32'd1);
      chk({tag, " idle J"}, {29'd0, dplus_out, dminus_out, tx_transfer_active}, 32'b100);
    end
  endtask
  function automatic void fill_rand(input int n);
    for (int i = 0; i < n; i++) pay[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
  endfunction
  initial begin
    for (int i = 0; i < 128; i++) pay[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {28'd0, dplus_out, dminus_out, tx_transfer_active, get_tx_data}, 32'h8);
    chk("reset err", {31'd0, tx_error}, 32'd0);
    @(negedge clk) n_rst = 1'b1;
    send(3'd3, 0, -1, -1, 1'b0, "ack");
    send(3'd1, 0, -1, -1, 1'b0, "zlp");
    pay[0] = 8'hFF;
    pay[1] = 8'hFF;
    send(3'd2, 2, -1, -1, 1'b0, "stuff");
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    send(3'd1, 9, -1, -1, 1'b1, "kat");
    bad_req(3'd6, 0, "reserved6");
    send(3'd3, 0, -1, -1, 1'b0, "ack clr1");
    bad_req(3'd1, 65, "occ65");
    bad_req(3'd7, 0, "reserved7");
    send(3'd3, 0, -1, -1, 1'b0, "ack clr2");
    fill_rand(64);
    send(3'd2, 64, -1, -1, 1'b0, "max64");
    send(3'd4, 0, -1, -1, 1'b0, "nak");
    send(3'd5, 0, -1, -1, 1'b0, "stall");
    fill_rand(4);
    send(3'd1, 4, 160, -1, 1'b0, "inject");
    fill_rand(8);
    send(3'd1, 8, -1, 200, 1'b0, "abort");
    send(3'd4, 0, -1, -1, 1'b0, "nak after rst");
    for (int t = 0; t < 8; t++) begin
      int n;
      logic [2:0] code;
      code = 3'($urandom_range(1, 5));
      n = $urandom_range(0, 16);
      fill_rand(n);
      send(code, n, -1, -1, 1'b0, $sformatf("rand%0d", t));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/usb_tx_engine.md
USB_TX_ENGINE -- requirements
Module: usb_tx_engine

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8: clock cycles per USB bit-time, minimum 4.
REQ-002 SHALL have parameter MAX_PAYLOAD, default 64: maximum data-packet payload in bytes.
REQ-003 SHALL have parameter OCC_W, default 7: width of buff_occ.
REQ-004 SHALL have parameter STUFF_EN, default 1: 1 enables bit stuffing, 0 bypasses it.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk and n_rst.
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 n_rst  input  1  asynchronous active-low reset.
REQ-008 tx_packet  input  3  request code: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6-7 reserved.
REQ-009 tx_packet_data  input  8  head byte of the TX buffer (show-ahead).
REQ-010 buff_occ  input  OCC_W  bytes held in the TX buffer.
REQ-011 get_tx_data  output  1  one-cycle pop strobe; tx_packet_data is sampled on the same edge.
REQ-012 tx_transfer_active  output  1  high while a packet is on the bus.
REQ-013 tx_error  output  1  sticky request error.
REQ-014 dplus_out, dminus_out  output  1 each  USB full-speed line drive.

Function
REQ-015 In IDLE, a nonzero tx_packet SHALL be accepted on that edge; transmission SHALL start on the next cycle, with tx_transfer_active rising on that cycle.
REQ-016 tx_packet SHALL be ignored outside IDLE.
REQ-017 Reserved codes, or DATA0/DATA1 with buff_occ > MAX_PAYLOAD, SHALL set tx_error and SHALL NOT transmit.
REQ-018 tx_error SHALL be cleared only by the next accepted valid request.
REQ-019 FSM states: IDLE -> SYNC -> PID -> {DATA -> CRC (data packets) | EOP (handshakes)} -> EOP -> IDLE.
REQ-020 DATA SHALL be skipped when the latched byte count is 0 (zero-length packet).
REQ-021 SYNC SHALL send byte 0x80 and PID SHALL send {~pid[3:0], pid[3:0]}, with pid DATA0=0x3, DATA1=0xB, ACK=0x2, NAK=0xA, STALL=0xE.
REQ-022 All bytes SHALL be sent LSB first, one bit per bit-time of CLKS_PER_BIT cycles.
REQ-023 buff_occ SHALL be latched at acceptance.
REQ-024 For each payload byte, get_tx_data SHALL pulse exactly once, in the cycle the byte is loaded; the load SHALL occur in the cycle the previous byte's last bit-time ends.
REQ-025 CRC16 SHALL use polynomial 0x8005 (reflected 0xA001) with initial value 0xFFFF, computed over payload bits only; the complemented remainder SHALL be sent LSB first.
REQ-026 Bit stuffing (STUFF_EN=1): after six consecutive 1 data bits, one 0 bit-time SHALL be inserted.
REQ-027 The ones-run counter SHALL reset on any 0 bit and at SYNC start, and SHALL run continuously across byte, PID and CRC boundaries.
REQ-028 A stuffed bit SHALL NOT advance the shift register or the CRC.
REQ-029 NRZI: a 0 bit SHALL toggle the line state and a 1 bit SHALL hold it.
REQ-030 The line state SHALL start at J (dplus_out=1, dminus_out=0), and K SHALL be driven as 0/1.
REQ-031 EOP SHALL drive SE0 (0/0) for 2 bit-times, then J for 1 bit-time.
REQ-032 tx_transfer_active SHALL fall on the cycle after the EOP J bit-time ends; IDLE SHALL drive J.
REQ-033 The bit timer SHALL restart at each acceptance, and its strobe SHALL fire on count CLKS_PER_BIT-1.

Reset
REQ-034 While n_rst=0, the block SHALL be in IDLE with dplus_out=1, dminus_out=0, tx_transfer_active=0, get_tx_data=0, tx_error=0, counters 0, CRC=0xFFFF.
REQ-035 Reset asserted mid-packet SHALL abort immediately with no EOP; the first request after release SHALL be accepted normally.

Structure
REQ-036 Package usb_tx_pkg SHALL hold: the request-code enum, PID constants, the FSM state enum, the CRC polynomial and initial value, and the stuff-run length 6.
REQ-037 A single sub-module usb_tx_crc16 SHALL be used: a serial CRC with clear, enable and data-bit inputs; all other logic SHALL be inline.

Verification
REQ-038 ACK, CLKS_PER_BIT=8: bit-times 00000001 + 01001011 + SE0, SE0, J; line sequence KJKJKJKK JJKJJKKK SE0 SE0 J; tx_transfer_active high for exactly 19*8=152 cycles.
REQ-039 DATA0 with buff_occ=0: PID byte 0xC3, CRC bytes 0x00 0x00, get_tx_data never pulses, 35 bit-times in total.
REQ-040 DATA1 with payload {0xFF, 0xFF}: stuffed 0s inserted after data bits 6 and 12; exactly 2 get_tx_data pulses; decoded payload and CRC match a reference model.
REQ-041 DATA0 with buff_occ=65: tx_error=1 and lines stay J; a following ACK clears tx_error and transmits.
REQ-042 n_rst pulsed mid-DATA: lines return to J asynchronously, tx_transfer_active=0, and a NAK issued afterward is bit-exact.
REQ-043 A new tx_packet=3 issued during an active DATA0: it is ignored and the packet completes unchanged.
